// File: rtl/pong_match_ctrl.sv
// Match sequencer for the VGA Pong ball datapath: serve / play / pause / point /
// game-over flow, programmable ball step rate with rally speed-ups, and scoring.
module pong_match_ctrl #(
    parameter int unsigned STEP_PERIOD  = 32'd500000,
    parameter int unsigned MIN_PERIOD   = 32'd100000,
    parameter int unsigned PERIOD_DEC   = 32'd50000,
    parameter int unsigned SPEEDUP_HITS = 32'd4,
    parameter int unsigned SERVE_CYCLES = 32'd25000000,
    parameter int unsigned WIN_SCORE    = 32'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       paddle_hit,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_step_en,
    output logic       ball_reload,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [3:0] WIN4 = 4'(WIN_SCORE);

    // Score increment that sticks at the 4-bit maximum.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        logic [3:0] res;
        if (s == 4'hF) begin
            res = s;
        end else begin
            res = s + 4'd1;
        end
        return res;
    endfunction

    // Shorter step period after a speed-up, floored at MIN_PERIOD without underflow.
    function automatic logic [31:0] speed_up(input logic [31:0] cur);
        logic [31:0] res;
        if ((cur > MIN_PERIOD) && ((cur - MIN_PERIOD) >= PERIOD_DEC)) begin
            res = cur - PERIOD_DEC;
        end else begin
            res = MIN_PERIOD;
        end
        return res;
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_start_q, r_pause_q;
    logic [31:0] r_step_cnt, w_step_cnt_nxt;
    logic [31:0] r_hit_cnt, w_hit_cnt_nxt;
    logic [31:0] r_serve_cnt, w_serve_cnt_nxt;
    logic [31:0] r_cur_period, w_cur_period_nxt;
    logic        r_step_en, w_step_en_nxt;
    logic        r_reload, w_reload_nxt;
    logic        r_serve_dir, w_serve_dir_nxt;
    logic [3:0]  r_score_l, w_score_l_nxt;
    logic [3:0]  r_score_r, w_score_r_nxt;
    logic        r_game_over, w_game_over_nxt;
    logic        w_start_edge, w_pause_edge;

    assign w_start_edge = start_btn & ~r_start_q;
    assign w_pause_edge = pause_btn & ~r_pause_q;

    // Next-state, counter and output decode for the match flow.
    always_comb begin
        w_state_nxt      = r_state;
        w_step_cnt_nxt   = r_step_cnt;
        w_hit_cnt_nxt    = r_hit_cnt;
        w_serve_cnt_nxt  = r_serve_cnt;
        w_cur_period_nxt = r_cur_period;
        w_step_en_nxt    = 1'b0;
        w_reload_nxt     = 1'b0;
        w_serve_dir_nxt  = r_serve_dir;
        w_score_l_nxt    = r_score_l;
        w_score_r_nxt    = r_score_r;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (w_start_edge) begin
                    w_state_nxt     = ST_SERVE;
                    w_score_l_nxt   = 4'd0;
                    w_score_r_nxt   = 4'd0;
                    w_serve_dir_nxt = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_SERVE: begin
                if (r_serve_cnt >= (SERVE_CYCLES - 32'd1)) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_serve_cnt_nxt = r_serve_cnt + 32'd1;
                end
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    // Simultaneous misses are a let: replay without scoring.
                    w_state_nxt = ST_POINT;
                end else if (miss_left) begin
                    w_state_nxt     = ST_POINT;
                    w_score_r_nxt   = sat_inc(r_score_r);
                    w_serve_dir_nxt = 1'b0;
                end else if (miss_right) begin
                    w_state_nxt     = ST_POINT;
                    w_score_l_nxt   = sat_inc(r_score_l);
                    w_serve_dir_nxt = 1'b1;
                end else if (w_pause_edge) begin
                    // Counts freeze from the pause edge onwards.
                    w_state_nxt = ST_PAUSE;
                end else begin
                    if (r_step_cnt >= (r_cur_period - 32'd1)) begin
                        w_step_cnt_nxt = 32'd0;
                        w_step_en_nxt  = 1'b1;
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + 32'd1;
                    end
                    if (paddle_hit) begin
                        if (r_hit_cnt >= (SPEEDUP_HITS - 32'd1)) begin
                            w_hit_cnt_nxt    = 32'd0;
                            w_cur_period_nxt = speed_up(r_cur_period);
                        end else begin
                            w_hit_cnt_nxt = r_hit_cnt + 32'd1;
                        end
                    end else begin
                        w_hit_cnt_nxt = r_hit_cnt;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_pause_edge) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_POINT: begin
                if ((r_score_l == WIN4) || (r_score_r == WIN4)) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_state_nxt = ST_SERVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Any entry into SERVE_WAIT restarts the serve and re-arms the ball.
        if ((w_state_nxt == ST_SERVE) && (r_state != ST_SERVE)) begin
            w_reload_nxt     = 1'b1;
            w_serve_cnt_nxt  = 32'd0;
            w_step_cnt_nxt   = 32'd0;
            w_cur_period_nxt = STEP_PERIOD;
        end else begin
            w_reload_nxt = 1'b0;
        end
        w_game_over_nxt = (w_state_nxt == ST_OVER);
    end

    // State, counters, button samples and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b1;
            r_pause_q    <= 1'b1;
            r_step_cnt   <= 32'd0;
            r_hit_cnt    <= 32'd0;
            r_serve_cnt  <= 32'd0;
            r_cur_period <= STEP_PERIOD;
            r_step_en    <= 1'b0;
            r_reload     <= 1'b0;
            r_serve_dir  <= 1'b1;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start_q    <= start_btn;
            r_pause_q    <= pause_btn;
            r_step_cnt   <= w_step_cnt_nxt;
            r_hit_cnt    <= w_hit_cnt_nxt;
            r_serve_cnt  <= w_serve_cnt_nxt;
            r_cur_period <= w_cur_period_nxt;
            r_step_en    <= w_step_en_nxt;
            r_reload     <= w_reload_nxt;
            r_serve_dir  <= w_serve_dir_nxt;
            r_score_l    <= w_score_l_nxt;
            r_score_r    <= w_score_r_nxt;
            r_game_over  <= w_game_over_nxt;
        end
    end

    assign state        = r_state;
    assign ball_step_en = r_step_en;
    assign ball_reload  = r_reload;
    assign serve_dir    = r_serve_dir;
    assign score_l      = r_score_l;
    assign score_r      = r_score_r;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with small parameters: a cycle table for
// reset, serve timing and the first speed-up, then hand sequences for the rest.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset, start_btn, pause_btn, paddle_hit, miss_left, miss_right;
    logic       ball_step_en, ball_reload, serve_dir, game_over;
    logic [3:0] score_l, score_r;
    logic [2:0] state;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .STEP_PERIOD (32'd4),
        .MIN_PERIOD  (32'd2),
        .PERIOD_DEC  (32'd1),
        .SPEEDUP_HITS(32'd2),
        .SERVE_CYCLES(32'd3),
        .WIN_SCORE   (32'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .paddle_hit  (paddle_hit),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .ball_step_en(ball_step_en),
        .ball_reload (ball_reload),
        .serve_dir   (serve_dir),
        .score_l     (score_l),
        .score_r     (score_r),
        .game_over   (game_over),
        .state       (state)
    );

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        hit;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[20];

    // Expected bundle {step, reload, dir, score_l, score_r, game_over, state}.
    function automatic logic [14:0] pack(input logic stp, input logic rl, input logic dir,
                                         input logic [3:0] sl, input logic [3:0] sr,
                                         input logic go, input logic [2:0] st);
        return {stp, rl, dir, sl, sr, go, st};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic h,
                                input logic stp, input logic rl, input logic [2:0] st);
        vec_t v;
        v.rst_n = r;
        v.start = s;
        v.hit   = h;
        v.exp   = pack(stp, rl, 1'b1, 4'd0, 4'd0, 1'b0, st);
        return v;
    endfunction

    function automatic logic [14:0] obs();
        return {ball_step_en, ball_reload, serve_dir, score_l, score_r, game_over, state};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic stp, input logic rl, input logic dir,
                              input logic [3:0] sl, input logic [3:0] sr,
                              input logic go, input logic [2:0] st);
        chk(nm, 32'(obs()), 32'(pack(stp, rl, dir, sl, sr, go, st)));
    endtask

    // Count cycles until the next step pulse; -1 if none within the budget.
    task automatic cycles_to_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (ball_step_en === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic measure_gap(output int g);
        int a;
        cycles_to_pulse(a);
        if (a < 0) begin
            g = -1;
        end else begin
            cycles_to_pulse(g);
        end
    endtask

    // Called right after the reload cycle was observed: two more SERVE cycles, then PLAY.
    task automatic run_serve(input string nm);
        tick();
        chk({nm, " serve2"}, 32'({ball_reload, state}), 32'({1'b0, 3'd1}));
        tick();
        chk({nm, " serve3"}, 32'({ball_reload, state}), 32'({1'b0, 3'd1}));
        tick();
        chk({nm, " play"}, 32'(state), 32'd2);
    endtask

    task automatic pulse_hits_pair();
        paddle_hit = 1'b1; tick();
        paddle_hit = 1'b0; tick();
        paddle_hit = 1'b1; tick();
        paddle_hit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        reset = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        paddle_hit = 1'b0; miss_left = 1'b0; miss_right = 1'b0;

        // rst, start, hit | step, reload, state
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        tbl[14] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);

        // Reset, serve timing, period 4, then two hits -> period 3.
        for (int i = 0; i < 20; i++) begin
            reset      = tbl[i].rst_n;
            start_btn  = tbl[i].start;
            paddle_hit = tbl[i].hit;
            tick();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end
        paddle_hit = 1'b0;

        // Two more hits -> period 2, two more -> still 2.
        pulse_hits_pair();
        measure_gap(n);
        chk("gap after 4 hits", 32'(n), 32'd2);
        pulse_hits_pair();
        measure_gap(n);
        chk("gap after 6 hits", 32'(n), 32'd2);

        // miss_left: point to the right player, re-serve at the base period.
        miss_left = 1'b1; tick(); miss_left = 1'b0;
        expect_out("miss_l point", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 3'd4);
        tick();
        expect_out("miss_l reload", 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 3'd1);
        run_serve("miss_l");
        cycles_to_pulse(n);
        chk("first pulse after reserve", 32'(n), 32'd4);

        // Pause with step_cnt=2, hold, resume: pulse 2 cycles later.
        tick(); tick();
        pause_btn = 1'b1; tick();
        expect_out("pause enter", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 3'd3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            miss_left  = (i == 4);
            paddle_hit = (i == 4);
            tick();
            if (ball_step_en !== 1'b0 || state !== 3'd3) bad++;
        end
        miss_left = 1'b0; paddle_hit = 1'b0;
        chk("pause hold bad cycles", 32'(bad), 32'd0);
        expect_out("pause ignores miss", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 3'd3);
        pause_btn = 1'b0; tick();
        pause_btn = 1'b1; tick();
        chk("resume state", 32'(state), 32'd2);
        cycles_to_pulse(n);
        chk("pulse after resume", 32'(n), 32'd2);
        pause_btn = 1'b0;

        // Both misses together: let, no score change.
        miss_left = 1'b1; miss_right = 1'b1; tick();
        miss_left = 1'b0; miss_right = 1'b0;
        expect_out("let point", 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 3'd4);
        tick();
        expect_out("let reload", 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 3'd1);
        run_serve("let");

        // miss_right beats a simultaneous pause edge.
        miss_right = 1'b1; pause_btn = 1'b1; tick();
        miss_right = 1'b0; pause_btn = 1'b0;
        expect_out("miss_r+pause", 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 3'd4);
        tick();
        expect_out("miss_r reload", 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 3'd1);
        run_serve("miss_r");

        // score_r reaches WIN_SCORE -> GAME_OVER; other inputs ignored there.
        miss_left = 1'b1; tick(); miss_left = 1'b0;
        expect_out("win point", 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 3'd4);
        tick();
        expect_out("game over", 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 3'd5);
        pause_btn = 1'b1; tick(); pause_btn = 1'b0;
        miss_left = 1'b1; miss_right = 1'b1; paddle_hit = 1'b1; tick();
        miss_left = 1'b0; miss_right = 1'b0; paddle_hit = 1'b0; tick();
        expect_out("game over hold", 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 3'd5);
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        expect_out("restart", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 3'd1);
        run_serve("restart");

        // Reset mid-PLAY, with start held through reset (no edge afterwards).
        tick(); tick();
        reset = 1'b0; start_btn = 1'b1; tick();
        expect_out("mid-play reset", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 3'd0);
        reset = 1'b1; tick();
        expect_out("held start no edge", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 3'd0);
        start_btn = 1'b0; tick();
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        expect_out("start after reset", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 3'd1);
        run_serve("post reset");
        cycles_to_pulse(n);
        chk("first pulse after reset", 32'(n), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
